// File: rtl/gpio_pkg.sv
// Shared defaults for the GPIO input-conditioning slice.
package gpio_pkg;

  localparam int GPIO_NUM_DEF     = 32;
  localparam int GPIO_SYNC_DEF    = 2;
  localparam int GPIO_CNT_W_DEF   = 8;
  localparam int GPIO_PRESC_W_DEF = 16;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin: pad synchroniser, tick-driven debounce counter and registered edge decode.
module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_DEF,
  parameter int CNT_WIDTH   = GPIO_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pad,
  input  logic                 filt_en,
  input  logic                 tick,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic                 filt,
  output logic                 rise,
  output logic                 fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   filt_d;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
    end
  end

  // cnt only advances on ticks and is cleared on acceptance, so it stays <= threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      filt_d <= filt;
      if (!filt_en) begin
        filt <= sync_q;
        cnt  <= '0;
      end else if (sync_q == filt) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt >= threshold) begin
          filt <= sync_q;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

endmodule

// File: rtl/gpio_input_filter.sv
// Conditions raw pad inputs for the GPIO controller: sync, debounce on a shared tick, edge strobes.
module gpio_input_filter
  import gpio_pkg::*;
#(
  parameter int NUM_GPIO       = GPIO_NUM_DEF,
  parameter int SYNC_STAGES    = GPIO_SYNC_DEF,
  parameter int CNT_WIDTH      = GPIO_CNT_W_DEF,
  parameter int PRESCALE_WIDTH = GPIO_PRESC_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_GPIO-1:0]       pad_i,
  input  logic [NUM_GPIO-1:0]       filt_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0]      threshold,
  output logic [NUM_GPIO-1:0]       gpio_filt_o,
  output logic [NUM_GPIO-1:0]       rise_o,
  output logic [NUM_GPIO-1:0]       fall_o,
  output logic                      tick_o
);

  localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE = 1;

  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic                      tick;

  // >= so that lowering prescale below the running count fires immediately instead of wrapping
  assign tick = (pcnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt   <= '0;
      tick_o <= 1'b0;
    end else begin
      pcnt   <= tick ? '0 : pcnt + PCNT_ONE;
      tick_o <= tick;
    end
  end

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .pad      (pad_i[i]),
      .filt_en  (filt_en[i]),
      .tick     (tick),
      .threshold(threshold),
      .filt     (gpio_filt_o[i]),
      .rise     (rise_o[i]),
      .fall     (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed and randomized bench for gpio_input_filter against a behavioural model.
module tb_gpio_input_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pad_i;
  logic [31:0] filt_en;
  logic [15:0] prescale;
  logic [7:0]  threshold;
  logic [31:0] gpio_filt_o, rise_o, fall_o;
  logic        tick_o;

  int checks = 0;
  int failures = 0;

  gpio_input_filter dut (
    .clk        (clk),
    .reset      (reset),
    .pad_i      (pad_i),
    .filt_en    (filt_en),
    .prescale   (prescale),
    .threshold  (threshold),
    .gpio_filt_o(gpio_filt_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .tick_o     (tick_o)
  );

  always #5 clk = ~clk;

  // model: two-deep pad history, per-pin run of mismatching ticks, free-running tick counter
  logic [31:0] m_s0, m_s1, m_filt, m_prev;
  int          m_run [32];
  int          m_pc;
  logic        m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tk;
    if (reset) begin
      m_s0 = '0; m_s1 = '0; m_filt = '0; m_prev = '0; m_pc = 0; m_tick = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      tk     = (m_pc >= int'(prescale));
      m_pc   = tk ? 0 : m_pc + 1;
      m_prev = m_filt;
      for (int i = 0; i < 32; i++) begin
        if (!filt_en[i]) begin
          m_filt[i] = m_s1[i];
          m_run[i]  = 0;
        end else if (m_s1[i] == m_filt[i]) begin
          m_run[i] = 0;
        end else if (tk) begin
          m_run[i]++;
          if (m_run[i] > int'(threshold)) begin
            m_filt[i] = m_s1[i];
            m_run[i]  = 0;
          end
        end
      end
      m_s1   = m_s0;
      m_s0   = pad_i;
      m_tick = tk;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_gpio", gpio_filt_o, m_filt);
    chk("model_rise", rise_o, m_filt & ~m_prev);
    chk("model_fall", fall_o, ~m_filt & m_prev);
    chk("model_tick", {31'd0, tick_o}, {31'd0, m_tick});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   found;
    logic saw;
    logic edge_seen;

    reset = 1'b1; pad_i = '0; filt_en = '0; prescale = '0; threshold = '0;
    steps(3);
    chk("reset_gpio", gpio_filt_o, 32'h0);
    chk("reset_rise", rise_o, 32'h0);
    chk("reset_fall", fall_o, 32'h0);
    chk("reset_tick", {31'd0, tick_o}, 32'h0);
    reset = 1'b0;
    steps(2);

    // bypass latency: 3 edges
    pad_i = 32'h0000_00A5;
    steps(2);
    chk("bypass_early", gpio_filt_o, 32'h0);
    step();
    chk("bypass_gpio", gpio_filt_o, 32'hA5);
    chk("bypass_rise", rise_o, 32'hA5);
    chk("bypass_fall", fall_o, 32'h0);
    step();
    chk("bypass_rise_once", rise_o, 32'h0);

    // glitch of 3 ticks with threshold 3 is rejected
    pad_i = '0; threshold = 8'd3;
    steps(5);
    filt_en = '1;
    steps(2);
    pad_i[0] = 1'b1;
    steps(3);
    pad_i[0] = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      saw |= gpio_filt_o[0] | rise_o[0];
    end
    chk("glitch_reject", {31'd0, saw}, 32'h0);

    // acceptance 6 edges after change, both directions
    pad_i[0] = 1'b1;
    n = 0; found = 0; edge_seen = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step();
      if (gpio_filt_o[0]) begin found = 1; n = k; edge_seen = rise_o[0]; end
    end
    chk("accept_rise_lat", n, 6);
    chk("accept_rise_pulse", {31'd0, edge_seen}, 32'h1);
    pad_i[0] = 1'b0;
    n = 0; found = 0; edge_seen = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step();
      if (!gpio_filt_o[0]) begin found = 1; n = k; edge_seen = fall_o[0]; end
    end
    chk("accept_fall_lat", n, 6);
    chk("accept_fall_pulse", {31'd0, edge_seen}, 32'h1);

    // prescaler: tick every 5, acceptance on 2nd tick, 1-tick mismatch rejected
    prescale = 16'd4; threshold = 8'd1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin step(); found = tick_o; end
    chk("presc_first_tick", {31'd0, found}, 32'h1);
    n = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin step(); if (tick_o) begin found = 1; n = k; end end
    chk("presc_period", n, 5);
    pad_i[0] = 1'b1;
    n = 0; found = 0;
    for (int k = 1; k <= 30 && !found; k++) begin step(); if (gpio_filt_o[0]) begin found = 1; n = k; end end
    chk("presc_accept", n, 10);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin step(); found = tick_o; end
    chk("presc_tick_again", {31'd0, found}, 32'h1);
    pad_i[0] = 1'b0;
    steps(5);
    pad_i[0] = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 15; k++) begin step(); saw |= ~gpio_filt_o[0]; end
    chk("presc_reject", {31'd0, saw}, 32'h0);

    // reset while a count of 2 is pending
    prescale = 16'd0; threshold = 8'd3;
    pad_i[0] = 1'b0;
    steps(4);
    reset = 1'b1;
    step();
    chk("midrst_gpio", gpio_filt_o, 32'h0);
    chk("midrst_rise", rise_o, 32'h0);
    chk("midrst_fall", fall_o, 32'h0);
    reset = 1'b0;
    steps(4);

    // bypass taken while counting
    pad_i[5] = 1'b1;
    steps(3);
    chk("bypass_switch_pre", {31'd0, gpio_filt_o[5]}, 32'h0);
    filt_en[5] = 1'b0;
    step();
    chk("bypass_switch", {31'd0, gpio_filt_o[5]}, 32'h1);
    filt_en[5] = 1'b1;
    steps(2);

    // prescale lowered below the running count
    prescale = 16'd100;
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(50);
    chk("presc_low_pre", {31'd0, tick_o}, 32'h0);
    prescale = 16'd3;
    step();
    chk("presc_low_tick", {31'd0, tick_o}, 32'h1);

    // independence of pins 0 and 31
    prescale = 16'd0; filt_en = '0;
    pad_i = 32'h8000_0000;
    steps(5);
    pad_i = 32'h0000_0001;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (rise_o[0]) begin
        found = 1;
        chk("indep_rise", rise_o, 32'h0000_0001);
        chk("indep_fall", fall_o, 32'h8000_0000);
      end
    end
    chk("indep_seen", {31'd0, found}, 32'h1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) pad_i = pad_i ^ ($urandom & $urandom);
      if ($urandom_range(0, 49) == 0) filt_en = $urandom;
      if ($urandom_range(0, 99) == 0) threshold = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) prescale = 16'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_input_filter.md
Name: gpio_input_filter

Overview:
- Input-conditioning stage directly upstream of the APB GPIO controller. Its filtered outputs drive the controller's gpio_i bus.
- Synchronises raw asynchronous pad inputs into clk.
- Debounces each pin with a shared programmable time base.
- Emits per-pin single-cycle rise/fall strobes.
- Static configuration inputs are driven by SoC control registers.

Parameters:
- NUM_GPIO, 32, number of pins.
- SYNC_STAGES, 2, synchroniser depth (>=2).
- CNT_WIDTH, 8, debounce counter and threshold width.
- PRESCALE_WIDTH, 16, tick prescaler width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- pad_i  in  NUM_GPIO  raw asynchronous pad inputs.
- filt_en  in  NUM_GPIO  per-pin filter enable; 0 = bypass (sync only).
- prescale  in  PRESCALE_WIDTH  tick period minus 1, in clk cycles.
- threshold  in  CNT_WIDTH  filtered change accepted after threshold+1 consecutive mismatching ticks.
- gpio_filt_o  out  NUM_GPIO  conditioned level; connects to GPIO gpio_i.
- rise_o  out  NUM_GPIO  1-cycle pulse on a filtered 0->1 transition.
- fall_o  out  NUM_GPIO  1-cycle pulse on a filtered 1->0 transition.
- tick_o  out  1  debounce time-base strobe.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sampled at a clk edge with reset=1) clears:
  - all synchroniser flops, the prescaler counter, every debounce counter and the filtered/delayed registers;
  - gpio_filt_o=0, rise_o=0, fall_o=0, tick_o=0, all visible after that edge.
- Reset mid-operation aborts any pending debounce count. No pulse is generated by reset itself.
- Synchroniser: SYNC_STAGES flops per pin; sync_q is the last stage. No reset-free flops.
- Prescaler:
  - pcnt increments each cycle.
  - When pcnt >= prescale: tick=1 that cycle, pcnt <= 0.
  - Using >= means lowering prescale mid-count never wraps.
  - prescale=0 gives a tick every cycle. tick_o is the registered tick.
- Per pin, filtered mode (filt_en[i]=1):
  - sync_q == filt: cnt <= 0.
  - Mismatch on a tick with cnt >= threshold: filt <= sync_q, cnt <= 0.
  - Mismatch on a tick with cnt < threshold: cnt <= cnt+1.
  - Mismatch on a non-tick cycle: cnt holds.
  - A mismatch lasting fewer than threshold+1 ticks is rejected; counting restarts from 0 on the next mismatch.
- Per pin, bypass (filt_en[i]=0): filt <= sync_q every cycle, cnt <= 0.
- filt_en changes:
  - 1->0: filt follows sync_q from the next cycle.
  - 0->1: counting starts from cnt=0.
- Latency, pad change stable before edge 0, prescale=0:
  - bypass: gpio_filt_o changes after SYNC_STAGES+1 edges;
  - filtered: after SYNC_STAGES+threshold+1 edges (threshold=0 equals bypass).
- Edges:
  - filt_d <= filt each cycle.
  - rise_o = filt & ~filt_d; fall_o = ~filt & filt_d. Both are decoded from registers only, so glitch-free.
  - Each pulse is coincident with the first cycle gpio_filt_o shows the new level, and lasts exactly 1 cycle.
  - rise and fall are never asserted together on one pin.
- Post-reset pins tied high: produce a rise_o pulse once accepted. This is required behaviour; the downstream controller's edge mode sees it.
- threshold or prescale changed mid-count: takes effect on the next comparison. No counter clear.
- Width rules:
  - cnt never exceeds threshold, so it cannot overflow.
  - All comparisons are unsigned.

Decomposition:
- Shared package gpio_pkg: default parameter constants (GPIO_NUM_DEF=32, GPIO_SYNC_DEF=2, GPIO_CNT_W_DEF=8, GPIO_PRESC_W_DEF=16).
- Sub-module gpio_debounce_cell: one pin's synchroniser, counter, filt, filt_d and edge decode. Instantiated NUM_GPIO times in a generate loop.
- The prescaler stays in the top and is shared by all cells.

Test Plan:
- Reset then bypass: all filt_en=0, pad_i 0->32'h0000_00A5 -> gpio_filt_o=32'hA5 after 3 edges; rise_o=32'hA5 for exactly 1 cycle; fall_o=0.
- Glitch rejection: filt_en=all 1, prescale=0, threshold=3, pin0 high for 3 cycles then low -> gpio_filt_o[0] stays 0; rise_o[0] never pulses.
- Acceptance timing: same config, pin0 held high -> gpio_filt_o[0]=1 exactly 6 edges after the change (2+3+1), with a rise_o[0] pulse. Release -> fall_o[0] 6 edges later.
- Prescaler: prescale=4, threshold=1 -> tick_o every 5 cycles. A stable pin change is accepted on the 2nd tick after the mismatch appears; a mismatch spanning 1 tick is rejected.
- Mid-operation events:
  - reset asserted while cnt=2 -> outputs 0 next cycle, no pulses;
  - filt_en 1->0 during counting -> gpio_filt_o follows sync_q the next cycle;
  - prescale lowered from 100 to 3 while pcnt=50 -> tick on the next cycle.
- Independence: pins 0 and 31 toggle simultaneously in opposite directions (one 0->1, the other 1->0) -> rise_o[0] and fall_o[31] pulse in the same cycle; other bits stay 0.
